// File: rtl/hex_loader.sv
// Intel HEX parser fed by the MiSTer download channel. Decoded data bytes are
// written into the program memory write port, one registered write per byte.
module hex_loader #(
  parameter int ADDR_ROM_BUS_WIDTH = 14
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          dl_active,
  input  logic                          dl_wr,
  input  logic [7:0]                    dl_data,
  output logic                          pm_we,
  output logic [ADDR_ROM_BUS_WIDTH-1:0] pm_addr,
  output logic [15:0]                   pm_din,
  output logic [1:0]                    pm_be,
  output logic                          core_rst,
  output logic                          done,
  output logic                          err
);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN, S_ADDR, S_TYPE, S_DATA, S_CHK, S_HALT
  } state_t;

  localparam logic [16:0] BYTE_SPACE = 17'd1 << (ADDR_ROM_BUS_WIDTH + 1);

  // Returns {valid, nibble}; valid is clear for anything but 0-9, A-F, a-f.
  function automatic logic [4:0] hex_decode(input logic [7:0] c);
    if (c >= 8'h30 && c <= 8'h39) begin
      return {1'b1, c[3:0]};
    end else if ((c >= 8'h41 && c <= 8'h46) || (c >= 8'h61 && c <= 8'h66)) begin
      return {1'b1, c[3:0] + 4'd9};
    end else begin
      return 5'd0;
    end
  endfunction

  state_t                        state_q, state_d, st_s;
  logic [1:0]                    nib_q, nib_d, nib_b_s;
  logic [3:0]                    hi_q, hi_d;
  logic [7:0]                    len_q, len_d;
  logic [15:0]                   addr_q, addr_d;
  logic [7:0]                    type_q, type_d;
  logic [7:0]                    idx_q, idx_d, idx_b_s;
  logic [7:0]                    sum_q, sum_d, sum_b_s;
  logic                          act_q, act_d;
  logic                          core_rst_q, core_rst_d;
  logic                          done_q, done_d;
  logic                          err_q, err_d;
  logic                          pm_we_q, pm_we_d;
  logic [ADDR_ROM_BUS_WIDTH-1:0] pm_addr_q, pm_addr_d;
  logic [15:0]                   pm_din_q, pm_din_d;
  logic [1:0]                    pm_be_q, pm_be_d;
  logic                          start_s;
  logic [4:0]                    hex_s;
  logic [7:0]                    byte_s, sum_new_s;
  logic [15:0]                   byte_addr_s;

  // Parser next-state, checksum and write-port computation.
  always_comb begin
    // A download start discards whatever the previous one left behind.
    start_s     = dl_active & ~act_q;
    st_s        = start_s ? S_IDLE : state_q;
    nib_b_s     = start_s ? 2'd0 : nib_q;
    idx_b_s     = start_s ? 8'd0 : idx_q;
    sum_b_s     = start_s ? 8'd0 : sum_q;
    hex_s       = hex_decode(dl_data);
    byte_s      = {hi_q, hex_s[3:0]};
    sum_new_s   = sum_b_s + byte_s;
    byte_addr_s = addr_q + {8'd0, idx_b_s};

    state_d    = st_s;
    nib_d      = nib_b_s;
    hi_d       = hi_q;
    len_d      = len_q;
    addr_d     = addr_q;
    type_d     = type_q;
    idx_d      = idx_b_s;
    sum_d      = sum_b_s;
    act_d      = dl_active;
    core_rst_d = dl_active;
    done_d     = start_s ? 1'b0 : done_q;
    err_d      = start_s ? 1'b0 : err_q;
    pm_we_d    = 1'b0;
    pm_addr_d  = pm_addr_q;
    pm_din_d   = pm_din_q;
    pm_be_d    = pm_be_q;

    if (dl_active && dl_wr) begin
      case (st_s)
        S_IDLE: begin
          if (dl_data == 8'h3A) begin
            state_d = S_LEN;
            nib_d   = 2'd0;
            idx_d   = 8'd0;
            sum_d   = 8'd0;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_HALT: begin
          state_d = S_HALT;
        end
        default: begin
          if (!hex_s[4]) begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end else if (!nib_b_s[0]) begin
            hi_d  = hex_s[3:0];
            nib_d = nib_b_s + 2'd1;
          end else begin
            sum_d = sum_new_s;
            nib_d = 2'd0;
            case (st_s)
              S_LEN: begin
                len_d   = byte_s;
                state_d = S_ADDR;
              end
              S_ADDR: begin
                if (!nib_b_s[1]) begin
                  addr_d[15:8] = byte_s;
                  nib_d        = 2'd2;
                end else begin
                  addr_d[7:0] = byte_s;
                  state_d     = S_TYPE;
                end
              end
              S_TYPE: begin
                type_d  = byte_s;
                idx_d   = 8'd0;
                state_d = (len_q == 8'd0) ? S_CHK : S_DATA;
              end
              S_DATA: begin
                if (type_q == 8'h00) begin
                  if ({1'b0, byte_addr_s} >= BYTE_SPACE) begin
                    err_d = 1'b1;
                  end else begin
                    pm_we_d   = 1'b1;
                    pm_addr_d = byte_addr_s[ADDR_ROM_BUS_WIDTH:1];
                    pm_din_d  = {byte_s, byte_s};
                    pm_be_d   = byte_addr_s[0] ? 2'b10 : 2'b01;
                  end
                end else begin
                  pm_we_d = 1'b0;
                end
                idx_d = idx_b_s + 8'd1;
                if (idx_b_s + 8'd1 == len_q) begin
                  state_d = S_CHK;
                end else begin
                  state_d = S_DATA;
                end
              end
              S_CHK: begin
                if (sum_new_s != 8'd0) begin
                  err_d   = 1'b1;
                  state_d = S_IDLE;
                end else if (type_q == 8'h01) begin
                  done_d  = 1'b1;
                  state_d = S_HALT;
                end else begin
                  state_d = S_IDLE;
                end
              end
              default: begin
                state_d = S_IDLE;
              end
            endcase
          end
        end
      endcase
    end else begin
      state_d = st_s;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      nib_q      <= 2'd0;
      hi_q       <= 4'd0;
      len_q      <= 8'd0;
      addr_q     <= 16'd0;
      type_q     <= 8'd0;
      idx_q      <= 8'd0;
      sum_q      <= 8'd0;
      act_q      <= 1'b0;
      core_rst_q <= 1'b1;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      pm_we_q    <= 1'b0;
      pm_addr_q  <= '0;
      pm_din_q   <= 16'd0;
      pm_be_q    <= 2'b00;
    end else begin
      state_q    <= state_d;
      nib_q      <= nib_d;
      hi_q       <= hi_d;
      len_q      <= len_d;
      addr_q     <= addr_d;
      type_q     <= type_d;
      idx_q      <= idx_d;
      sum_q      <= sum_d;
      act_q      <= act_d;
      core_rst_q <= core_rst_d;
      done_q     <= done_d;
      err_q      <= err_d;
      pm_we_q    <= pm_we_d;
      pm_addr_q  <= pm_addr_d;
      pm_din_q   <= pm_din_d;
      pm_be_q    <= pm_be_d;
    end
  end

  assign pm_we    = pm_we_q;
  assign pm_addr  = pm_addr_q;
  assign pm_din   = pm_din_q;
  assign pm_be    = pm_be_q;
  assign core_rst = core_rst_q;
  assign done     = done_q;
  assign err      = err_q;

endmodule
